// File: rtl/in_fifo_rd_sched.sv
// in_fifo_rd_sched: read-side scheduler for a group of byte-lane IN_FIFOs on one
// read clock. Issues a common read only when every lane holds data, captures the
// lane words into a 2-entry valid/ready output buffer, watches for lane skew and
// runs a drain sequence to resynchronise the lanes.
//
// Ports:
//   clk, rst_n  : read clock (RDCLK of all lanes), async active-low reset
//   en          : scheduling enable
//   flush       : single-cycle drain request, wins over every other transition
//   fifo_empty  : per-lane EMPTY flags
//   fifo_q      : lane data, lane i at [i*LANE_W +: LANE_W]
//   fifo_rden   : per-lane RDEN (combinational from state, occupancy, empties)
//   dout/dvalid : head word of the output buffer and its valid
//   dready      : consumer accepts dout
//   busy        : high while draining
//   skew_err    : sticky lane-skew error, cleared by a completed drain
module in_fifo_rd_sched #(
   parameter int unsigned LANES    = 4,
   parameter int unsigned LANE_W   = 80,
   parameter int unsigned SKEW_MAX = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      flush,
   input  logic [LANES-1:0]          fifo_empty,
   input  logic [LANES*LANE_W-1:0]   fifo_q,
   output logic [LANES-1:0]          fifo_rden,
   output logic [LANES*LANE_W-1:0]   dout,
   output logic                      dvalid,
   input  logic                      dready,
   output logic                      busy,
   output logic                      skew_err
);

   localparam int unsigned DW = LANES * LANE_W;
   localparam int unsigned SW = $clog2(SKEW_MAX + 1);
   localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW_MAX - 1);
   localparam logic [SW-1:0] SKEW_TOP  = SW'(SKEW_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t          state_q, state_n;
   logic [1:0]      occ_q, occ_n;
   logic            inflight_q;
   logic [SW-1:0]   skew_cnt_q, skew_cnt_n;
   logic            skew_err_n;
   logic            flush_seen_q, flush_seen_n;
   logic [DW-1:0]   buf1_q, buf1_n, dout_n;
   logic            issue;
   logic            push, pop;
   logic            all_rdy, all_empty, partial;
   logic [2:0]      used;

   assign all_rdy   = ~|fifo_empty;
   assign all_empty = &fifo_empty;
   assign partial   = !all_rdy && !all_empty;

   // Buffer handshakes; the buffer is frozen in ERR and discarded by a flush.
   assign pop  = dvalid && dready && (state_q != S_ERR);
   assign push = inflight_q && !flush;

   // Slots committed for the next capture; a pop this edge frees one, which is
   // what sustains one read per cycle with a 2-entry buffer.
   assign used = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

   // Next-state, read issue, skew tracking and drain exit.
   always_comb begin
      state_n      = state_q;
      fifo_rden    = '0;
      issue        = 1'b0;
      skew_cnt_n   = skew_cnt_q;
      skew_err_n   = skew_err;
      flush_seen_n = flush_seen_q;
      unique case (state_q)
         S_IDLE: begin
            if (en) state_n = S_RUN;
         end
         S_RUN: begin
            issue = en && all_rdy && (used < 3'd2);
            if (partial) begin
               if (skew_cnt_q == SKEW_LAST) begin
                  skew_cnt_n = SKEW_TOP;
                  skew_err_n = 1'b1;
                  state_n    = S_ERR;
               end else begin
                  skew_cnt_n = skew_cnt_q + SW'(1);
               end
            end else begin
               skew_cnt_n = '0;
            end
            if (!en && state_n == S_RUN) state_n = S_IDLE;
         end
         S_FLUSH: begin
            fifo_rden = ~fifo_empty;
            if (all_empty) begin
               if (flush_seen_q) begin
                  state_n      = en ? S_RUN : S_IDLE;
                  skew_cnt_n   = '0;
                  skew_err_n   = 1'b0;
                  flush_seen_n = 1'b0;
               end else begin
                  flush_seen_n = 1'b1;
               end
            end else begin
               flush_seen_n = 1'b0;
            end
         end
         S_ERR: begin
         end
         default: state_n = S_IDLE;
      endcase
      // A flush request overrides every other transition and restarts the drain.
      if (flush) begin
         state_n      = S_FLUSH;
         issue        = 1'b0;
         flush_seen_n = 1'b0;
         skew_cnt_n   = skew_cnt_q;
         skew_err_n   = skew_err;
      end
      if (issue) fifo_rden = {LANES{1'b1}};
   end

   // Output buffer: dout is the head entry, buf1_q the second entry.
   always_comb begin
      occ_n  = occ_q;
      dout_n = dout;
      buf1_n = buf1_q;
      if (flush) begin
         occ_n = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b11: begin
               if (occ_q == 2'd2) begin
                  dout_n = buf1_q;
                  buf1_n = fifo_q;
               end else begin
                  dout_n = fifo_q;
               end
            end
            2'b10: begin
               if (occ_q == 2'd0) dout_n = fifo_q;
               else               buf1_n = fifo_q;
               occ_n = occ_q + 2'd1;
            end
            2'b01: begin
               dout_n = buf1_q;
               occ_n  = occ_q - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         occ_q        <= 2'd0;
         inflight_q   <= 1'b0;
         skew_cnt_q   <= '0;
         skew_err     <= 1'b0;
         flush_seen_q <= 1'b0;
         busy         <= 1'b0;
         dvalid       <= 1'b0;
         dout         <= '0;
         buf1_q       <= '0;
      end else begin
         state_q      <= state_n;
         occ_q        <= occ_n;
         inflight_q   <= issue;
         skew_cnt_q   <= skew_cnt_n;
         skew_err     <= skew_err_n;
         flush_seen_q <= flush_seen_n;
         busy         <= (state_n == S_FLUSH);
         dvalid       <= (occ_n != 2'd0);
         dout         <= dout_n;
         buf1_q       <= buf1_n;
      end
   end

   // The credit rule keeps a capture from ever landing in a full buffer.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (occ_q == 2'd2)));

endmodule

// File: tb/tb_in_fifo_rd_sched.sv
// tb_in_fifo_rd_sched: directed bench for in_fifo_rd_sched with a behavioural
// model of the IN_FIFO lanes and a scoreboard of expected output words.
module tb_in_fifo_rd_sched;

   localparam int unsigned LANES    = 4;
   localparam int unsigned LANE_W   = 80;
   localparam int unsigned SKEW_MAX = 7;
   localparam int unsigned DW       = LANES * LANE_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             flush = 1'b0;
   logic             dready = 1'b1;
   logic [LANES-1:0] fifo_empty = '1;
   logic [DW-1:0]    fifo_q = '0;
   logic [LANES-1:0] fifo_rden;
   logic [DW-1:0]    dout;
   logic             dvalid;
   logic             busy;
   logic             skew_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rden_cnt, first_rden, last_rden, first_dv, got_cnt;

   logic [LANE_W-1:0] lq [LANES][$];
   logic [DW-1:0]     exp_q [$];

   in_fifo_rd_sched #(.LANES(LANES), .LANE_W(LANE_W), .SKEW_MAX(SKEW_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
      .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rden(fifo_rden),
      .dout(dout), .dvalid(dvalid), .dready(dready),
      .busy(busy), .skew_err(skew_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // IN_FIFO lane model: data appears one edge after RDEN, EMPTY updates on the edge.
   always @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (fifo_rden[i] && lq[i].size() != 0)
            fifo_q[i*LANE_W +: LANE_W] <= lq[i].pop_front();
         fifo_empty[i] <= (lq[i].size() == 0);
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LANE_W-1:0] wd(input int lane, input int k);
      return LANE_W'((lane << 16) | k);
   endfunction

   function automatic logic [DW-1:0] full_word(input int k);
      logic [DW-1:0] w;
      for (int l = 0; l < LANES; l++) w[l*LANE_W +: LANE_W] = wd(l, k);
      return w;
   endfunction

   // Observation and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fifo_rden == '1) begin
            rden_cnt++;
            if (first_rden < 0) first_rden = cyc;
            last_rden = cyc;
         end
         if (dvalid && first_dv < 0) first_dv = cyc;
         if (dvalid && dready) begin
            got_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $error("FAIL unexpected_word observed=%0h expected=none", dout);
            end else begin
               chk("dout_order", dout, exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rden_cnt = 0; first_rden = -1; last_rden = -1; first_dv = -1; got_cnt = 0;
   endtask

   task automatic load(input logic [LANES-1:0] mask, input int k0, input int n, input bit expect_out);
      for (int k = k0; k < k0 + n; k++) begin
         for (int l = 0; l < LANES; l++)
            if (mask[l]) lq[l].push_back(wd(l, k));
         if (expect_out) exp_q.push_back(full_word(k));
      end
   endtask

   initial begin
      clr();
      tick(1);
      chk("rst_rden", DW'(fifo_rden), DW'(0));
      chk("rst_dout", dout, '0);
      chk("rst_dvalid", DW'(dvalid), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_skew_err", DW'(skew_err), DW'(0));
      rst_n = 1'b1;
      tick(1);

      // Aligned stream at full throughput.
      clr();
      load('1, 1, 8, 1'b1);
      en = 1'b1;
      tick(20);
      chk("stream_rden_cnt", DW'(rden_cnt), DW'(8));
      chk("stream_rden_span", DW'(last_rden - first_rden), DW'(7));
      chk("stream_latency", DW'(first_dv - first_rden), DW'(2));
      chk("stream_got", DW'(got_cnt), DW'(8));
      chk("stream_idle_dvalid", DW'(dvalid), DW'(0));

      // Backpressure: buffer fills after two reads and holds its head.
      dready = 1'b0;
      clr();
      load('1, 'h11, 8, 1'b1);
      tick(10);
      chk("bp_rden_cnt", DW'(rden_cnt), DW'(2));
      chk("bp_dvalid", DW'(dvalid), DW'(1));
      chk("bp_head", dout, full_word('h11));
      tick(3);
      chk("bp_hold", dout, full_word('h11));
      dready = 1'b1;
      tick(20);
      chk("bp_got", DW'(got_cnt), DW'(8));
      chk("bp_scoreboard_empty", DW'(exp_q.size()), DW'(0));

      // Skew: lane 2 empty, error after SKEW_MAX cycles, then drain.
      clr();
      load(4'b1011, 'h21, 3, 1'b0);
      tick(7);
      chk("skew_before", DW'(skew_err), DW'(0));
      tick(1);
      chk("skew_set", DW'(skew_err), DW'(1));
      chk("skew_no_rden", DW'(rden_cnt), DW'(0));
      tick(2);
      chk("err_rden", DW'(fifo_rden), DW'(0));
      chk("err_busy", DW'(busy), DW'(0));
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      chk("skflush_busy_entry", DW'(busy), DW'(1));
      tick(4);
      chk("skflush_busy_hold", DW'(busy), DW'(1));
      chk("skflush_err_hold", DW'(skew_err), DW'(1));
      tick(1);
      chk("skflush_busy_done", DW'(busy), DW'(0));
      chk("skflush_err_clear", DW'(skew_err), DW'(0));
      chk("skflush_drained", DW'(fifo_empty), DW'(4'hF));

      // Flush with a full buffer, then resume in RUN.
      dready = 1'b0;
      clr();
      load('1, 'h31, 4, 1'b0);
      tick(6);
      chk("bflush_pre_dvalid", DW'(dvalid), DW'(1));
      chk("bflush_pre_rden", DW'(rden_cnt), DW'(2));
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      chk("bflush_dvalid", DW'(dvalid), DW'(0));
      chk("bflush_busy", DW'(busy), DW'(1));
      tick(4);
      chk("bflush_done", DW'(busy), DW'(0));
      chk("bflush_drained", DW'(fifo_empty), DW'(4'hF));
      dready = 1'b1;
      clr();
      load('1, 'h41, 1, 1'b1);
      tick(6);
      chk("bflush_resume", DW'(got_cnt), DW'(1));

      // Asynchronous reset in the middle of a read.
      dready = 1'b0;
      clr();
      load('1, 'h51, 8, 1'b0);
      tick(2);
      chk("ar_rden_active", DW'(fifo_rden), DW'(4'hF));
      #2 rst_n = 1'b0;
      #1;
      chk("ar_rden", DW'(fifo_rden), DW'(0));
      chk("ar_dout", dout, '0);
      chk("ar_dvalid", DW'(dvalid), DW'(0));
      chk("ar_busy", DW'(busy), DW'(0));
      tick(1);
      rst_n = 1'b1;
      en = 1'b0;
      clr();
      tick(3);
      chk("ar_idle_rden", DW'(rden_cnt), DW'(0));
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(12);
      chk("ar_drained", DW'(fifo_empty), DW'(4'hF));
      chk("ar_flush_idle", DW'(busy), DW'(0));
      clr();
      load('1, 'h61, 1, 1'b1);
      tick(3);
      chk("idle_no_read", DW'(rden_cnt), DW'(0));
      dready = 1'b1;
      en = 1'b1;
      tick(6);
      chk("idle_to_run", DW'(got_cnt), DW'(1));

      // Flush in the same cycle the skew limit is reached: flush wins.
      clr();
      load(4'b1011, 'h71, 2, 1'b0);
      tick(7);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      chk("race_skew_err", DW'(skew_err), DW'(0));
      chk("race_busy", DW'(busy), DW'(1));
      tick(4);
      chk("race_done", DW'(busy), DW'(0));
      chk("race_err_final", DW'(skew_err), DW'(0));
      chk("race_drained", DW'(fifo_empty), DW'(4'hF));
      chk("final_scoreboard", DW'(exp_q.size()), DW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
